// File: rtl/clock_divider_prog.sv
// clock_divider_prog
//   Runtime-programmable clock divider. Produces a one-cycle clock enable at
//   the start of each divided period, a one-cycle enable at the falling edge
//   of the divided clock, and the divided clock itself (combinatorial use
//   only; do not route it as a clock). A new divisor is captured into a
//   pending register and only takes effect at a period boundary, so the
//   divided clock never shows a truncated or stretched phase.
//
// Ports
//   CLK      source clock, rising edge
//   RESET    asynchronous, active-high reset
//   ENABLE   1 = count, 0 = freeze counter and divided clock level
//   DIVISOR  divisor value captured when LOAD=1
//   LOAD     capture DIVISOR into the pending register
//   SYNC     restart the period at phase 0 (applies any pending divisor)
//   CE       one-cycle pulse at the start of each divided period
//   CE_FALL  one-cycle pulse at the falling edge of CLOCK
//   CLOCK    divided clock, high for ceil(active/2) cycles
//   PENDING  a loaded divisor is waiting for the next period boundary
module clock_divider_prog #(
  parameter int WIDTH         = 16,
  parameter int RESET_DIVISOR = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] DIVISOR,
  input  logic             LOAD,
  input  logic             SYNC,
  output logic             CE,
  output logic             CE_FALL,
  output logic             CLOCK,
  output logic             PENDING
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pend_val;
  logic             pend;

  logic [WIDTH:0]   high;
  logic             at_wrap;
  logic             apply;

  // One extra bit so active = 2**WIDTH-1 cannot overflow when rounding up.
  assign high    = ({1'b0, active} + (WIDTH+1)'(1)) >> 1;
  assign at_wrap = (cnt == active - WIDTH'(1));

  // A stopped divider (active==0) has no period boundary, so a pending value
  // is taken on the next edge even while disabled; otherwise it waits for
  // the enabled edge that closes the current period.
  assign apply = pend && ((active == '0) ||
                          (ENABLE && ((active == WIDTH'(1)) || at_wrap)));

  assign PENDING = pend;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      active   <= WIDTH'(RESET_DIVISOR);
      pend_val <= '0;
      pend     <= 1'b0;
      CE       <= 1'b0;
      CE_FALL  <= 1'b0;
      CLOCK    <= 1'b0;
    end else begin
      if (SYNC) begin
        cnt     <= '0;
        CE      <= 1'b0;
        CE_FALL <= 1'b0;
        CLOCK   <= 1'b0;
        if (pend) begin
          active <= pend_val;
          pend   <= 1'b0;
        end
      end else begin
        if (active == '0) begin
          CE      <= 1'b0;
          CE_FALL <= 1'b0;
          CLOCK   <= 1'b0;
          cnt     <= '0;
        end else if (!ENABLE) begin
          // CLOCK and cnt hold so resuming loses no phase.
          CE      <= 1'b0;
          CE_FALL <= 1'b0;
        end else if (active == WIDTH'(1)) begin
          CE      <= 1'b1;
          CE_FALL <= 1'b0;
          CLOCK   <= 1'b0;
          cnt     <= '0;
        end else begin
          CE      <= (cnt == '0);
          CE_FALL <= ({1'b0, cnt} == high);
          CLOCK   <= ({1'b0, cnt} < high);
          cnt     <= at_wrap ? '0 : cnt + WIDTH'(1);
        end

        if (apply) begin
          active <= pend_val;
          pend   <= 1'b0;
          cnt    <= '0;
        end
      end

      // Last: a LOAD coinciding with an apply/SYNC becomes the next pending
      // value while the older one is consumed.
      if (LOAD) begin
        pend_val <= DIVISOR;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b1;
  logic [15:0] DIVISOR = '0;
  logic        LOAD = 1'b0;
  logic        SYNC = 1'b0;
  logic        CE, CE_FALL, CLOCK, PENDING;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] exp_q[$];

  clock_divider_prog #(.WIDTH(16), .RESET_DIVISOR(4)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIVISOR(DIVISOR),
    .LOAD(LOAD), .SYNC(SYNC), .CE(CE), .CE_FALL(CE_FALL),
    .CLOCK(CLOCK), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  // Expected word layout: {CE, CE_FALL, CLOCK, PENDING}
  task automatic step(input logic en, input logic ld, input logic [15:0] dv,
                      input logic sy, input logic [3:0] e);
    ENABLE  = en;
    LOAD    = ld;
    DIVISOR = dv;
    SYNC    = sy;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic e1(input logic [3:0] e);
    step(1'b1, 1'b0, 16'd0, 1'b0, e);
  endtask

  // Monitor: pops one expectation per edge that has one queued.
  initial begin
    logic [3:0] got, want;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {CE, CE_FALL, CLOCK, PENDING};
        checks++;
        cyc++;
        if (got !== want) begin
          errors++;
          $display("FAIL out cyc %0d got {ce,cef,clk,pend}=%b exp %b", cyc, got, want);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got stimulus unfinished exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({CE, CE_FALL, CLOCK, PENDING} !== 4'b0000) begin
      errors++;
      $display("FAIL reset got %b exp 0000", {CE, CE_FALL, CLOCK, PENDING});
    end
    RESET = 1'b0;

    // divisor 4 from reset
    repeat (2) begin e1(4'b1010); e1(4'b0010); e1(4'b0100); e1(4'b0000); end

    // LOAD 5 at cnt=1, current 4-cycle period untouched
    e1(4'b1010); step(1, 1, 16'd5, 0, 4'b0011); e1(4'b0101); e1(4'b0000);
    repeat (2) begin e1(4'b1010); e1(4'b0010); e1(4'b0010); e1(4'b0100); e1(4'b0000); end

    // LOAD 7 then LOAD 3: only 3 is applied
    step(1, 1, 16'd7, 0, 4'b1011); step(1, 1, 16'd3, 0, 4'b0011);
    e1(4'b0011); e1(4'b0101); e1(4'b0000);
    repeat (2) begin e1(4'b1010); e1(4'b0010); e1(4'b0100); end

    // divisor 6, freeze at cnt=2 for 10 cycles
    step(1, 1, 16'd6, 0, 4'b1011); e1(4'b0011); e1(4'b0100);
    e1(4'b1010); e1(4'b0010);
    repeat (10) step(0, 0, 16'd0, 0, 4'b0010);
    e1(4'b0010); e1(4'b0100); e1(4'b0000); e1(4'b0000); e1(4'b1010);

    // divisor 8, pending 2, SYNC at cnt=3
    step(1, 1, 16'd8, 0, 4'b0011); e1(4'b0011); e1(4'b0101); e1(4'b0001); e1(4'b0000);
    step(1, 1, 16'd2, 0, 4'b1011); e1(4'b0011); e1(4'b0011);
    step(1, 0, 16'd0, 1, 4'b0000);
    e1(4'b1010); e1(4'b0100); e1(4'b1010); e1(4'b0100);

    // LOAD 0 stops; LOAD 1 applied while disabled; divisor 1
    step(1, 1, 16'd0, 0, 4'b1011); e1(4'b0100);
    e1(4'b0000); e1(4'b0000); e1(4'b0000);
    step(1, 1, 16'd1, 0, 4'b0001); step(0, 0, 16'd0, 0, 4'b0000);
    e1(4'b1000); e1(4'b1000); e1(4'b1000);
    step(0, 0, 16'd0, 0, 4'b0000); e1(4'b1000);
    step(1, 1, 16'd9, 0, 4'b1001);

    // asynchronous reset mid-sequence discards pending 9
    RESET = 1'b1;
    #1;
    checks++;
    if ({CE, CE_FALL, CLOCK, PENDING} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b exp 0000", {CE, CE_FALL, CLOCK, PENDING});
    end
    @(negedge CLK);
    RESET = 1'b0;
    e1(4'b1010); e1(4'b0010);

    // SYNC and LOAD together: SYNC applies 5, 2 becomes pending
    step(1, 1, 16'd5, 0, 4'b0101);
    step(1, 1, 16'd2, 1, 4'b0001);
    e1(4'b1011); e1(4'b0011); e1(4'b0011); e1(4'b0101); e1(4'b0000);
    e1(4'b1010); e1(4'b0100);

    @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
